// File: rtl/scrambler_ctrl.sv
// Per-lane sequencer for the bit-serial PCIe Gen1/Gen2 scrambler LFSR engine.
// Classifies each symbol, drives seed/shift controls and returns the result via valid/ready.
module scrambler_ctrl #(
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  COM_SYM    = 8'hBC,
    parameter logic [DATA_WIDTH-1:0]  SKP_SYM    = 8'h1C
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [DATA_WIDTH-1:0] sym_i,
    input  logic                  sym_k_i,
    input  logic                  sym_bypass_i,
    input  logic                  sym_valid_i,
    output logic                  sym_ready_o,

    output logic [DATA_WIDTH-1:0] out_sym_o,
    output logic                  out_k_o,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,

    output logic                  eng_seed_o,
    output logic                  eng_shift_o,
    input  logic                  eng_ks_i
);

    localparam int unsigned      IDX_W    = $clog2(DATA_WIDTH);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_SHIFT,
        ST_EMIT
    } state_e;

    state_e                  state_q,    state_d;
    logic [IDX_W-1:0]        idx_q,      idx_d;
    logic [DATA_WIDTH-1:0]   out_sym_q,  out_sym_d;
    logic                    out_k_q,    out_k_d;
    logic                    scramble_q, scramble_d;
    logic                    com_seed_q, com_seed_d;

    logic is_com;
    logic is_skp;

    assign is_com = sym_k_i && (sym_i == COM_SYM);
    assign is_skp = sym_k_i && (sym_i == SKP_SYM);

    // The captured symbol is scrambled in place one bit per shift cycle, so
    // out_sym_q doubles as the capture register and the output holding register.
    always_comb begin
        // NOTE: every *_d gets a default first so no path through the case infers a latch.
        state_d    = state_q;
        idx_d      = idx_q;
        out_sym_d  = out_sym_q;
        out_k_d    = out_k_q;
        scramble_d = scramble_q;
        com_seed_d = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                state_d = ST_IDLE;
            end

            ST_IDLE: begin
                if (sym_valid_i) begin
                    out_sym_d = sym_i;
                    out_k_d   = sym_k_i;
                    idx_d     = '0;
                    if (is_com) begin
                        state_d    = ST_EMIT;
                        scramble_d = 1'b0;
                        com_seed_d = 1'b1;
                    end else if (is_skp) begin
                        state_d    = ST_EMIT;
                        scramble_d = 1'b0;
                    end else begin
                        state_d    = ST_SHIFT;
                        scramble_d = !sym_k_i && !sym_bypass_i;
                    end
                end
            end

            ST_SHIFT: begin
                out_sym_d[idx_q] = out_sym_q[idx_q] ^ (scramble_q & eng_ks_i);
                idx_d            = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_EMIT;
                end
            end

            ST_EMIT: begin
                if (out_ready_i) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_INIT;
            idx_q      <= '0;
            out_sym_q  <= '0;
            out_k_q    <= 1'b0;
            scramble_q <= 1'b0;
            com_seed_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            out_sym_q  <= out_sym_d;
            out_k_q    <= out_k_d;
            scramble_q <= scramble_d;
            com_seed_q <= com_seed_d;
        end
    end

    // INIT seed is gated by rst_i so it fires only in the first released cycle.
    assign sym_ready_o = (state_q == ST_IDLE);
    assign out_valid_o = (state_q == ST_EMIT);
    assign eng_shift_o = (state_q == ST_SHIFT);
    assign eng_seed_o  = ((state_q == ST_INIT) && !rst_i) || com_seed_q;
    assign out_sym_o   = out_sym_q;
    assign out_k_o     = out_k_q;

endmodule

// File: tb/tb_scrambler_ctrl.sv
// Directed self-checking bench for scrambler_ctrl; the bench itself plays the LFSR engine
// by driving eng_ks_i with a per-cycle keystream pattern.
module tb_scrambler_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic [7:0] sym_i;
    logic       sym_k_i;
    logic       sym_bypass_i;
    logic       sym_valid_i;
    logic       sym_ready_o;
    logic [7:0] out_sym_o;
    logic       out_k_o;
    logic       out_valid_o;
    logic       out_ready_i;
    logic       eng_seed_o;
    logic       eng_shift_o;
    logic       eng_ks_i;

    int n_checks = 0;
    int n_errors = 0;

    scrambler_ctrl dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .sym_i        (sym_i),
        .sym_k_i      (sym_k_i),
        .sym_bypass_i (sym_bypass_i),
        .sym_valid_i  (sym_valid_i),
        .sym_ready_o  (sym_ready_o),
        .out_sym_o    (out_sym_o),
        .out_k_o      (out_k_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .eng_seed_o   (eng_seed_o),
        .eng_shift_o  (eng_shift_o),
        .eng_ks_i     (eng_ks_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Accepts one symbol in IDLE, plays ks[i] during shift cycle i, and stops
    // in the first EMIT cycle after checking the result.
    task automatic send_shifted(input string tag, input logic [7:0] sym, input logic k,
                                input logic byp, input logic [7:0] ks, input logic [7:0] exp_sym);
        int shifts;
        int seeds;
        shifts       = 0;
        seeds        = 0;
        sym_i        = sym;
        sym_k_i      = k;
        sym_bypass_i = byp;
        sym_valid_i  = 1'b1;
        settle();
        check({tag, "_ready"}, 32'(sym_ready_o), 32'd1);
        tick();
        sym_valid_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            eng_ks_i = ks[i];
            settle();
            if (eng_shift_o) shifts++;
            if (eng_seed_o)  seeds++;
            tick();
        end
        eng_ks_i = 1'b0;
        settle();
        check({tag, "_shifts"}, 32'(shifts),      32'd8);
        check({tag, "_seeds"},  32'(seeds),       32'd0);
        check({tag, "_valid"},  32'(out_valid_o), 32'd1);
        check({tag, "_sym"},    32'(out_sym_o),   32'(exp_sym));
        check({tag, "_k"},      32'(out_k_o),     32'(k));
        check({tag, "_noshift"},32'(eng_shift_o), 32'd0);
    endtask

    initial begin
        rst_i        = 1'b1;
        sym_i        = 8'h00;
        sym_k_i      = 1'b0;
        sym_bypass_i = 1'b0;
        sym_valid_i  = 1'b0;
        out_ready_i  = 1'b1;
        eng_ks_i     = 1'b0;

        repeat (3) tick();
        settle();
        check("rst_ready", 32'(sym_ready_o), 32'd0);
        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_sym",   32'(out_sym_o),   32'h00);
        check("rst_k",     32'(out_k_o),     32'd0);
        check("rst_seed",  32'(eng_seed_o),  32'd0);
        check("rst_shift", 32'(eng_shift_o), 32'd0);

        // First released cycle: INIT seeds the engine.
        rst_i = 1'b0;
        settle();
        check("init_seed",  32'(eng_seed_o),  32'd1);
        check("init_ready", 32'(sym_ready_o), 32'd0);
        tick();
        settle();
        check("idle_seed",  32'(eng_seed_o),  32'd0);
        check("idle_ready", 32'(sym_ready_o), 32'd1);

        // COM: seed pulse and output at cycle 1, no shift.
        sym_i       = 8'hBC;
        sym_k_i     = 1'b1;
        sym_valid_i = 1'b1;
        tick();
        sym_valid_i = 1'b0;
        settle();
        check("com_valid", 32'(out_valid_o), 32'd1);
        check("com_sym",   32'(out_sym_o),   32'hBC);
        check("com_k",     32'(out_k_o),     32'd1);
        check("com_seed",  32'(eng_seed_o),  32'd1);
        check("com_shift", 32'(eng_shift_o), 32'd0);
        check("com_ready", 32'(sym_ready_o), 32'd0);
        tick();
        settle();
        check("com_done_valid", 32'(out_valid_o), 32'd0);
        check("com_done_seed",  32'(eng_seed_o),  32'd0);

        // Back-to-back: accepted in the cycle right after the COM transfer.
        send_shifted("d00", 8'h00, 1'b0, 1'b0, 8'hFF, 8'hFF);
        tick();
        settle();
        check("d00_idle", 32'(sym_ready_o), 32'd1);

        send_shifted("a5_byp", 8'hA5, 1'b0, 1'b1, 8'hFF, 8'hA5);
        tick();

        // SKP: no seed, no shift.
        sym_i       = 8'h1C;
        sym_k_i     = 1'b1;
        sym_valid_i = 1'b1;
        tick();
        sym_valid_i = 1'b0;
        settle();
        check("skp_valid", 32'(out_valid_o), 32'd1);
        check("skp_sym",   32'(out_sym_o),   32'h1C);
        check("skp_seed",  32'(eng_seed_o),  32'd0);
        check("skp_shift", 32'(eng_shift_o), 32'd0);
        tick();

        // Other K passes through unscrambled; a D-coded 0xBC is scrambled (0xBC ^ 0xFF).
        send_shifted("stp", 8'hFB, 1'b1, 1'b0, 8'hFF, 8'hFB);
        tick();
        send_shifted("d_bc", 8'hBC, 1'b0, 1'b0, 8'hFF, 8'h43);
        tick();

        // Keystream 1,0,1,0... from idx0 is 0x55; 0x0F ^ 0x55 = 0x5A. Downstream stalls.
        out_ready_i = 1'b0;
        send_shifted("d0f", 8'h0F, 1'b0, 1'b0, 8'h55, 8'h5A);
        for (int i = 0; i < 5; i++) begin
            tick();
            settle();
            check("stall_sym",   32'(out_sym_o),   32'h5A);
            check("stall_valid", 32'(out_valid_o), 32'd1);
            check("stall_shift", 32'(eng_shift_o), 32'd0);
            check("stall_ready", 32'(sym_ready_o), 32'd0);
        end
        out_ready_i = 1'b1;
        tick();
        settle();
        check("stall_done_valid", 32'(out_valid_o), 32'd0);
        check("stall_done_ready", 32'(sym_ready_o), 32'd1);

        // Reset while shifting at idx=4.
        sym_i        = 8'h33;
        sym_k_i      = 1'b0;
        sym_bypass_i = 1'b0;
        sym_valid_i  = 1'b1;
        tick();
        sym_valid_i = 1'b0;
        eng_ks_i    = 1'b1;
        repeat (4) tick();
        settle();
        check("mid_shift", 32'(eng_shift_o), 32'd1);
        rst_i = 1'b1;
        tick();
        settle();
        check("mid_rst_ready", 32'(sym_ready_o), 32'd0);
        check("mid_rst_valid", 32'(out_valid_o), 32'd0);
        check("mid_rst_sym",   32'(out_sym_o),   32'h00);
        check("mid_rst_k",     32'(out_k_o),     32'd0);
        check("mid_rst_seed",  32'(eng_seed_o),  32'd0);
        check("mid_rst_shift", 32'(eng_shift_o), 32'd0);
        rst_i    = 1'b0;
        eng_ks_i = 1'b0;
        settle();
        check("reinit_seed",  32'(eng_seed_o),  32'd1);
        check("reinit_ready", 32'(sym_ready_o), 32'd0);
        tick();
        settle();
        check("reidle_seed",  32'(eng_seed_o),  32'd0);
        check("reidle_ready", 32'(sym_ready_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
